// File: rtl/bullet_pool_pkg.sv
// Shared bullet/playfield constants used by the pool, ship,
// collision checker and enemy shooter.
package bullet_pool_pkg;

    localparam int COORD_WIDTH = 10;
    localparam int PLAY_Y_MIN  = 0;
    localparam int PLAY_Y_MAX  = 479;
    localparam int SPAWN_Y_POS = 240;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef struct packed {
        logic [COORD_WIDTH-1:0] x;
        logic [COORD_WIDTH-1:0] y;
        logic                   dir;
        logic                   live;
    } slot_t;

endpackage

// File: rtl/bullet_slot.sv
// One projectile: position/direction/live registers,
// vertical motion with playfield expiry, and box-hit test.
module bullet_slot
    import bullet_pool_pkg::*;
#(
    parameter int COORD_W = COORD_WIDTH,
    parameter int SPEED   = 2,
    parameter int HALF_W  = 4,
    parameter int HALF_H  = 8,
    parameter int Y_MIN   = PLAY_Y_MIN,
    parameter int Y_MAX   = PLAY_Y_MAX
) (
    input  logic               clk_60hz,
    input  logic               reset,
    input  logic               spawn,
    input  logic               kill,
    input  logic [COORD_W-1:0] spawn_x,
    input  logic [COORD_W-1:0] spawn_y,
    input  logic               spawn_dir,
    input  logic [COORD_W-1:0] px,
    input  logic [COORD_W-1:0] py,
    output logic               live,
    output logic               live_next,
    output logic               hit
);

    localparam logic [COORD_W-1:0] UP_LIM = COORD_W'(Y_MIN + SPEED);
    localparam logic [COORD_W-1:0] DN_LIM = COORD_W'(Y_MAX - SPEED);
    localparam logic [COORD_W-1:0] STEP   = COORD_W'(SPEED);
    localparam logic [COORD_W:0]   HW     = (COORD_W+1)'(HALF_W);
    localparam logic [COORD_W:0]   HH     = (COORD_W+1)'(HALF_H);

    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] y_next;
    logic               dir;

    // Limits are checked before stepping so y never wraps.
    always_comb begin
        live_next = live;
        y_next    = y;
        if (spawn) begin
            live_next = 1'b1;
            y_next    = spawn_y;
        end else if (kill) begin
            live_next = 1'b0;
        end else if (live) begin
            if (dir == DIR_UP) begin
                if (y < UP_LIM) live_next = 1'b0;
                else            y_next    = y - STEP;
            end else begin
                if (y > DN_LIM) live_next = 1'b0;
                else            y_next    = y + STEP;
            end
        end
    end

    always_ff @(posedge clk_60hz) begin
        if (!reset) begin
            live <= 1'b0;
            x    <= '0;
            y    <= '0;
            dir  <= 1'b0;
        end else begin
            live <= live_next;
            y    <= y_next;
            if (spawn) begin
                x   <= spawn_x;
                dir <= spawn_dir;
            end
        end
    end

    logic signed [COORD_W:0] dx;
    logic signed [COORD_W:0] dy;
    logic        [COORD_W:0] adx;
    logic        [COORD_W:0] ady;

    always_comb begin
        dx  = $signed({1'b0, px}) - $signed({1'b0, x});
        dy  = $signed({1'b0, py}) - $signed({1'b0, y});
        adx = dx[COORD_W] ? $unsigned(-dx) : $unsigned(dx);
        ady = dy[COORD_W] ? $unsigned(-dy) : $unsigned(dy);
        hit = live && (adx < HW) && (ady < HH);
    end

endmodule

// File: rtl/bullet_pool.sv
// Pool of independent bullets: lowest-free allocation with refire
// cooldown, external kills, live count and scan-position hit.
module bullet_pool
    import bullet_pool_pkg::*;
#(
    parameter int NUM_BULLETS = 4,
    parameter int IDX_W       = 2,
    parameter int COORD_W     = COORD_WIDTH,
    parameter int SPEED       = 2,
    parameter int HALF_W      = 4,
    parameter int HALF_H      = 8,
    parameter int SPAWN_Y     = SPAWN_Y_POS,
    parameter int Y_MIN       = PLAY_Y_MIN,
    parameter int Y_MAX       = PLAY_Y_MAX,
    parameter int COOLDOWN    = 8
) (
    input  logic                   clk_60hz,
    input  logic                   reset,
    input  logic [COORD_W-1:0]     px,
    input  logic [COORD_W-1:0]     py,
    input  logic                   fire,
    input  logic                   direction,
    input  logic [COORD_W-1:0]     shipX,
    input  logic                   kill_valid,
    input  logic [IDX_W-1:0]       kill_idx,
    output logic                   fire_ack,
    output logic [IDX_W-1:0]       fire_idx,
    output logic [NUM_BULLETS-1:0] in_use,
    output logic [IDX_W:0]         active_count,
    output logic                   pixel,
    output logic [IDX_W-1:0]       pixel_idx
);

    localparam int CD_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

    logic [CD_W-1:0]        cd;
    logic [NUM_BULLETS-1:0] spawn;
    logic [NUM_BULLETS-1:0] kill;
    logic [NUM_BULLETS-1:0] live_next;
    logic [NUM_BULLETS-1:0] hit;
    logic                   free_any;
    logic [IDX_W-1:0]       free_idx;
    logic                   accept;
    logic [IDX_W:0]         cnt_next;

    // Free slots come from the pre-edge in_use, so a slot vacated
    // this tick is only reusable on the next one.
    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
            if (!in_use[i]) begin
                free_any = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
        accept = fire && (cd == '0) && free_any;
    end

    always_comb begin
        spawn    = '0;
        kill     = '0;
        cnt_next = '0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            spawn[i] = accept && (free_idx == IDX_W'(i));
            kill[i]  = kill_valid && (kill_idx == IDX_W'(i));
            cnt_next = cnt_next + (IDX_W+1)'(live_next[i]);
        end
    end

    always_comb begin
        pixel     = |hit;
        pixel_idx = '0;
        for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
            if (hit[i]) pixel_idx = IDX_W'(i);
        end
    end

    always_ff @(posedge clk_60hz) begin
        if (!reset) begin
            fire_ack     <= 1'b0;
            fire_idx     <= '0;
            cd           <= '0;
            active_count <= '0;
        end else begin
            fire_ack     <= accept;
            active_count <= cnt_next;
            if (accept) begin
                fire_idx <= free_idx;
                cd       <= CD_W'(COOLDOWN);
            end else if (cd != '0) begin
                cd <= cd - CD_W'(1);
            end
        end
    end

    for (genvar s = 0; s < NUM_BULLETS; s++) begin : g_slot
        bullet_slot #(
            .COORD_W (COORD_W),
            .SPEED   (SPEED),
            .HALF_W  (HALF_W),
            .HALF_H  (HALF_H),
            .Y_MIN   (Y_MIN),
            .Y_MAX   (Y_MAX)
        ) u_slot (
            .clk_60hz  (clk_60hz),
            .reset     (reset),
            .spawn     (spawn[s]),
            .kill      (kill[s]),
            .spawn_x   (shipX),
            .spawn_y   (COORD_W'(SPAWN_Y)),
            .spawn_dir (direction),
            .px        (px),
            .py        (py),
            .live      (in_use[s]),
            .live_next (live_next[s]),
            .hit       (hit[s])
        );
    end

endmodule

// File: doc/bullet_pool.md
Name: bullet_pool

Overview:
- Parametrised pool of NUM_BULLETS independent projectiles. It replaces the single-bullet block used by the ship and enemy shooters.
- Each clk_60hz tick it does four things:
  - allocates the lowest free slot on a fire request, gated by a refire cooldown;
  - advances every live bullet vertically;
  - retires bullets that leave the playfield;
  - frees slots on external kill requests from collision logic.
- Also provides a combinational pixel hit for the VGA scan position, with the index of the lowest-numbered bullet drawn.

Parameters:
- NUM_BULLETS, 4, number of bullet slots (1..16).
- IDX_W, 2, slot index width (clog2(NUM_BULLETS), minimum 1).
- COORD_W, 10, coordinate width.
- SPEED, 2, pixels moved per tick.
- HALF_W, 4, horizontal half-extent of the drawn box.
- HALF_H, 8, vertical half-extent of the drawn box.
- SPAWN_Y, 240, initial Y of a new bullet.
- Y_MIN, 0, top playfield limit (inclusive).
- Y_MAX, 479, bottom playfield limit (inclusive).
- COOLDOWN, 8, ticks between accepted shots (0 means every tick).

Ports:
- clk_60hz  in  1  frame-rate clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset.
- px  in  COORD_W  current scan X.
- py  in  COORD_W  current scan Y.
- fire  in  1  level fire request.
- direction  in  1  1 = new bullet travels up, 0 = down.
- shipX  in  COORD_W  spawn X.
- kill_valid  in  1  free slot kill_idx this tick.
- kill_idx  in  IDX_W  slot to free.
- fire_ack  out  1  one-tick pulse: shot accepted.
- fire_idx  out  IDX_W  slot allocated (valid with fire_ack).
- in_use  out  NUM_BULLETS  per-slot live flags.
- active_count  out  IDX_W+1  number of live slots.
- pixel  out  1  scan position inside any live bullet box.
- pixel_idx  out  IDX_W  lowest live slot hit (0 when pixel=0).

Behaviour:
- Reset: when reset=0 at an edge, the following are cleared:
  - in_use, fire_ack, fire_idx, cooldown counter, active_count, all slot X/Y/dir registers.
  - This applies mid-flight too: all bullets vanish the next tick.
- Per-slot state: x (COORD_W), y (COORD_W), dir (1), live (1).
- Cooldown:
  - counter cd, width clog2(COOLDOWN+1).
  - Decrements by 1 each tick while nonzero.
  - Loaded with COOLDOWN on an accepted shot; the load overrides the decrement.
- Fire acceptance condition: fire=1, cd==0, and at least one slot free.
  - Free is judged on the in_use value before this edge.
  - On acceptance:
    - allocate the lowest free index;
    - x=shipX, y=SPAWN_Y, dir=direction, live=1;
    - fire_ack=1 and fire_idx=index for exactly one tick.
  - Otherwise fire_ack=0 and fire_idx holds its last value.
  - fire held high with COOLDOWN=8 yields one accept every 9 ticks.
- Movement: each live slot not killed this tick does one of:
  - up: if y < Y_MIN+SPEED, set live=0; else y -= SPEED.
  - down: if y > Y_MAX-SPEED, set live=0; else y += SPEED.
  - Compare before the subtract so there is no wrap-around.
  - A freshly spawned bullet does not move on its spawn tick.
- Kill: kill_valid frees slot kill_idx and takes priority over movement for that slot.
  - Kill of an already-free slot: no effect.
  - kill_idx >= NUM_BULLETS: ignored.
- Slot reuse: a slot freed this tick (by kill or expiry) cannot be allocated until the next tick.
  - Kill and fire in the same tick with the pool full: fire is rejected and cd is unchanged.
- active_count: registered popcount of the next in_use value, so it stays consistent with in_use.
- Pixel (combinational, no clock):
  - Slot s hits when live, |px-x| < HALF_W and |py-y| < HALF_H.
  - Differences are computed at COORD_W+1 bits signed, so there is no underflow at coordinate 0.
  - pixel = OR of all hits; pixel_idx = lowest hitting index.
  - No latches: outputs are fully assigned on every path.

Decomposition:
- Shared package/header: coordinate width, playfield limits, SPAWN_Y, direction encoding (DIR_UP=1), slot-state field widths. These are reused by the ship, the collision checker and the enemy shooter.
- One natural sub-module: bullet_slot.
  - Holds one slot's x/y/dir/live registers, movement/expiry logic and box-hit comparator.
  - Inputs: spawn, kill, spawn values.
  - Instantiated NUM_BULLETS times.
- Lowest-free and lowest-hit priority encoders plus the popcount stay in bullet_pool.

Test Plan:
- Reset then fire=1 for 1 tick with shipX=100, direction=1 -> fire_ack=1, fire_idx=0. Next tick: in_use=0001, y=240. Following tick: y=238.
- fire held high, COOLDOWN=8, NUM_BULLETS=4 -> accepts on ticks 0, 9, 18, 27 into slots 0..3. Tick 36: no ack (pool full), active_count=4.
- Up bullet spawned at y=240, SPEED=2 -> live through y=0 after 120 moves, freed on the next tick (0 < Y_MIN+2). Down bullet -> freed after y=478.
- Pool full, kill_valid=1 kill_idx=2 and fire=1 with cd=0 in the same tick -> no ack that tick, slot 2 freed. Fire next tick -> fire_idx=2.
- Slot 0 at (100,240): px=96 -> pixel=0; px=97, py=233 -> pixel=1; py=232 -> 0. Slots 0 and 1 overlapping -> pixel_idx=0.
- reset=0 asserted with 3 live bullets and cd=5 -> next tick in_use=0, active_count=0, cd=0. After reset=1, a fire is accepted immediately.
